pyc_sync_filter: RTL and testbench

Multi-channel single-bit input conditioner for the destination clock domain. Each channel has:
- a STAGES-deep synchronizer chain;
- a stability (deglitch) filter;
- registered rise/fall edge-pulse generation.

It sits at the boundary of every block that consumes asynchronous or foreign-domain control bits (interrupt lines, handshake toggles, external straps). Multi-bit buses stay on dedicated CDC protocols; channels here are independent bits with no mutual coherence guarantee.

---
 rtl/pyc_sync_filter.sv | 93 +++++++++
 tb/tb_pyc_sync_filter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pyc_sync_filter.sv
// Per-channel synchronizer, deglitch filter and registered edge pulses; level/rise/fall lag `in` by STAGES+FILTER edges.
// No backpressure: every channel is sampled on every clk edge, and no output has a combinational path from `in`.
module pyc_sync_filter #(
  parameter int                  CHANNELS  = 4,
  parameter int                  STAGES    = 2,
  parameter int                  FILTER    = 1,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

`ifdef PYC_TARGET_FPGA
  (* async_reg = "true" *) logic [STAGES-1:0] sync_q [CHANNELS];
`else
  logic [STAGES-1:0] sync_q [CHANNELS];
`endif

  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {STAGES{RESET_VAL[c]}};
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c][0] <= in[c];
        for (int i = 1; i < STAGES; i++) begin
          sync_q[c][i] <= sync_q[c][i-1];
        end
      end
    end
  end

  // Any cycle where sync agrees with level throws away a partially counted change.
  always_comb begin
    sync   = '0;
    accept = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt[c] = '0;
      sync[c]    = sync_q[c][STAGES-1];
      if (sync[c] != level[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          accept[c] = 1'b1;
        end else begin
          cnt_nxt[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= RESET_VAL;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      level    <= level ^ accept;
      rise     <= accept & ~level;
      fall     <= accept & level;
      any_edge <= |accept;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_nxt[c];
      end
    end
  end

`ifndef SYNTHESIS
  initial begin
    if (CHANNELS < 1 || STAGES < 1 || FILTER < 1) begin
      $error("pyc_sync_filter: CHANNELS, STAGES and FILTER must all be >= 1");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_pyc_sync_filter.sv
// Randomised and directed stimulus for pyc_sync_filter, checked against a sample-window reference model.
module tb_pyc_sync_filter;

  localparam int         CH = 4;
  localparam int         ST = 2;
  localparam int         FI = 3;
  localparam logic [3:0] RV = 4'b0100;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_v = 4'b1011;
  logic [3:0] level, rise, fall;
  logic       any_edge;

  exp_t       expq[$];
  logic [3:0] hist[$];
  logic [3:0] m_level;
  int         n_vec = 0;
  int         n_bad = 0;

  pyc_sync_filter #(
    .CHANNELS (CH),
    .STAGES   (ST),
    .FILTER   (FI),
    .RESET_VAL(RV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_v),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  // Model state: the last ST+FI input samples; the filter at an edge looks at
  // the FI samples taken ST..ST+FI-1 edges earlier.
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < ST + FI; i++) hist.push_back(RV);
    m_level = RV;
  endtask

  task automatic model_edge();
    exp_t       e;
    logic [3:0] acc;
    logic       ok;
    if (!rst_n) begin
      model_reset();
      e = '{RV, 4'b0, 4'b0, 1'b0};
    end else begin
      hist.push_back(in_v);
      void'(hist.pop_front());
      acc = '0;
      for (int c = 0; c < CH; c++) begin
        ok = 1'b1;
        for (int j = 0; j < FI; j++) begin
          if (hist[j][c] == m_level[c]) ok = 1'b0;
        end
        acc[c] = ok;
      end
      e.rise  = acc & ~m_level;
      e.fall  = acc & m_level;
      e.any   = |acc;
      m_level = m_level ^ acc;
      e.level = m_level;
    end
    expq.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] v, input logic r);
    @(negedge clk);
    in_v  = v;
    rst_n = r;
    if (!r) begin
      #1;
      n_vec++;
      if ({level, rise, fall, any_edge} !== {RV, 4'b0, 4'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold t=%0t got level=%b rise=%b fall=%b any=%b want level=%b rise=0000 fall=0000 any=0",
                 $time, level, rise, fall, any_edge, RV);
      end
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b1);
  endtask

  // Monitor: every edge produces a new output word, compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_vec++;
        if ({level, rise, fall, any_edge} !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got level=%b rise=%b fall=%b any=%b want level=%b rise=%b fall=%b any=%b",
                   $time, level, rise, fall, any_edge, e.level, e.rise, e.fall, e.any);
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    model_reset();
    // Reset held with inputs opposing RESET_VAL, then a quiet release.
    repeat (3) cycle(4'b1011, 1'b0);
    hold(RV, 20);
    // Single rising channel, then back down.
    hold(4'b0101, 8);
    hold(RV, 8);
    // Two-cycle glitch is swallowed; three-cycle pulse passes.
    hold(4'b0110, 2);
    hold(RV, 8);
    hold(4'b0110, 3);
    hold(RV, 10);
    // Falling edge on the channel that resets high.
    hold(4'b0000, 8);
    hold(RV, 8);
    // Two channels rising together.
    hold(4'b1101, 8);
    hold(RV, 8);
    // Reset lands while channel 3 has a partial count.
    hold(4'b1100, 3);
    repeat (2) cycle(4'b1100, 1'b0);
    hold(4'b1100, 8);
    hold(RV, 8);
    // Random bit flips with occasional resets.
    v = RV;
    for (int i = 0; i < 2000; i++) begin
      v = v ^ (4'($urandom) & 4'($urandom));
      cycle(v, ($urandom_range(0, 99) != 0));
    end
    hold(v, 6);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
